// File: rtl/symbol_deserializer.sv
// symbol_deserializer
// Recovers 8-bit words from a UART-like serial stream (start 0, eight data
// bits MSB first, stop 1) whose bit period is a programmable number of clk
// cycles. Good words are classified against three known patterns and counted.
module symbol_deserializer #(
    parameter int unsigned CYC_W          = 24,
    parameter logic [7:0]  PAT0           = 8'hCC,
    parameter logic [7:0]  PAT1           = 8'hAA,
    parameter logic [7:0]  PAT2           = 8'h33,
    // Reset value of the good-frame counter; leave at 0 for normal use.
    parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic [CYC_W-1:0] symbol_clk_cycles,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic [1:0]       ch_id,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CYC_W-1:0] N_MIN = CYC_W'(2);
    localparam logic [CYC_W-1:0] ONE   = CYC_W'(1);

    state_t state;
    state_t state_next;

    // Synchronizer stages; s is the only view of the line used by the FSM.
    logic sync1;
    logic s;
    logic s_prev;

    logic [CYC_W-1:0] n_eff;
    logic [CYC_W-1:0] half;
    logic [CYC_W-1:0] cnt;
    logic [CYC_W-1:0] target;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic fall;
    logic tick;
    logic start_det;
    logic start_ok;
    logic bit_take;
    logic stop_good;
    logic stop_bad;

    // A period below two cycles would put the mid-bit sample on the edge.
    function automatic logic [CYC_W-1:0] clamp_period(input logic [CYC_W-1:0] n);
        return (n < N_MIN) ? N_MIN : n;
    endfunction

    function automatic logic [1:0] classify(input logic [7:0] w);
        if (w == PAT0) return 2'd0;
        if (w == PAT1) return 2'd1;
        if (w == PAT2) return 2'd2;
        return 2'd3;
    endfunction

    assign fall   = s_prev & ~s;
    assign half   = n_eff >> 1;
    // START waits half a period to land mid-bit; later bits are one period apart.
    assign target = (state == START) ? half : n_eff;
    assign tick   = (cnt == target);

    // Two-flop synchronizer plus the previous-sample flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            s      <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            sync1  <= d_in;
            s      <= sync1;
            s_prev <= s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle sampling strobes.
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        start_ok   = 1'b0;
        bit_take   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s) begin
                        // Line went back high: glitch, not a start bit.
                        state_next = IDLE;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    bit_take = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    stop_good  = s;
                    stop_bad   = ~s;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Symbol-period counter; the period is frozen at start detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            n_eff <= N_MIN;
        end else if (start_det) begin
            cnt   <= ONE;
            n_eff <= clamp_period(symbol_clk_cycles);
        end else if (state != IDLE) begin
            cnt <= tick ? ONE : cnt + ONE;
        end else begin
            cnt <= '0;
        end
    end

    // Data-bit shifter, MSB arrives first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (start_ok) begin
            bit_idx <= 3'd0;
        end else if (bit_take) begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {shreg[6:0], s};
        end
    end

    // Result registers: publish a good word or flag a framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 8'h00;
            ch_id      <= 2'd3;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= FRAME_CNT_INIT;
        end else begin
            data_valid <= stop_good;
            frame_err  <= stop_bad;
            if (stop_good) begin
                data_out  <= shreg;
                ch_id     <= classify(shreg);
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_symbol_deserializer.sv
// Directed bench for symbol_deserializer: table of single frames plus
// hand-written sequences for back-to-back, glitch, reset and period corners.
module tb_symbol_deserializer;

    logic        clk;
    logic        rst;
    logic        d_in;
    logic [23:0] sym;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [1:0]  ch_id;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [7:0]  w_data_out;
    logic        w_data_valid;
    logic [1:0]  w_ch_id;
    logic        w_frame_err;
    logic [15:0] w_frame_cnt;

    symbol_deserializer dut (
        .clk(clk), .rst(rst), .d_in(d_in), .symbol_clk_cycles(sym),
        .data_out(data_out), .data_valid(data_valid), .ch_id(ch_id),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    // Second copy with the counter preset near the top to reach the wrap.
    symbol_deserializer #(.FRAME_CNT_INIT(16'hFFFF)) dut_w (
        .clk(clk), .rst(rst), .d_in(d_in), .symbol_clk_cycles(sym),
        .data_out(w_data_out), .data_valid(w_data_valid), .ch_id(w_ch_id),
        .frame_err(w_frame_err), .frame_cnt(w_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int vtot = 0;
    int etot = 0;
    int both = 0;
    int v0, e0;
    logic [1:0] ch_h0, ch_h1;
    logic [7:0] d_h0, d_h1;

    always @(negedge clk) begin
        if (data_valid) begin
            vtot  <= vtot + 1;
            ch_h0 <= ch_id;
            ch_h1 <= ch_h0;
            d_h0  <= data_out;
            d_h1  <= d_h0;
        end
        if (frame_err) etot <= etot + 1;
        if (data_valid && frame_err) both <= both + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive the first nbits of {start, w[7:0] MSB first, stop}, len cycles each.
    task automatic send(input logic [7:0] w, input logic stop, input int len,
                        input int nbits, input bit tail_low);
        logic [9:0] fr;
        fr[0] = 1'b0;
        for (int k = 0; k < 8; k++) fr[k+1] = w[7-k];
        fr[9] = stop;
        for (int i = 0; i < nbits; i++) begin
            d_in = fr[i];
            repeat (len) @(negedge clk);
        end
        d_in = tail_low ? 1'b0 : 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        v0 = vtot;
        e0 = etot;
    endtask

    typedef struct {
        int         cfg;
        int         len;
        logic [7:0] w;
        logic       stop;
        int         ev;
        int         ee;
        logic [7:0] ed;
        logic [1:0] ec;
        logic [15:0] en;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{cfg: 4,  len: 4,  w: 8'h5A, stop: 1'b0, ev: 0, ee: 1, ed: 8'hCC, ec: 2'd0, en: 16'd1};
        tbl[1] = '{cfg: 3,  len: 3,  w: 8'h33, stop: 1'b1, ev: 1, ee: 0, ed: 8'h33, ec: 2'd2, en: 16'd2};
        tbl[2] = '{cfg: 0,  len: 2,  w: 8'hAA, stop: 1'b1, ev: 1, ee: 0, ed: 8'hAA, ec: 2'd1, en: 16'd3};
        tbl[3] = '{cfg: 5,  len: 5,  w: 8'h5A, stop: 1'b1, ev: 1, ee: 0, ed: 8'h5A, ec: 2'd3, en: 16'd4};
        tbl[4] = '{cfg: 1,  len: 2,  w: 8'hCC, stop: 1'b1, ev: 1, ee: 0, ed: 8'hCC, ec: 2'd0, en: 16'd5};
        tbl[5] = '{cfg: 16, len: 16, w: 8'h01, stop: 1'b0, ev: 0, ee: 1, ed: 8'hCC, ec: 2'd0, en: 16'd5};
        tbl[6] = '{cfg: 7,  len: 7,  w: 8'h80, stop: 1'b1, ev: 1, ee: 0, ed: 8'h80, ec: 2'd3, en: 16'd6};

        rst  = 1'b1;
        d_in = 1'b1;
        sym  = 24'd4;
        idle(3);
        chk("rst data_out", data_out, 8'h00);
        chk("rst ch_id", ch_id, 2'd3);
        chk("rst data_valid", data_valid, 1'b0);
        chk("rst frame_err", frame_err, 1'b0);
        chk("rst frame_cnt", frame_cnt, 16'd0);
        chk("rst preset cnt", w_frame_cnt, 16'hFFFF);
        chk("rst preset pulses", {w_data_valid, w_frame_err}, 2'b00);
        rst = 1'b0;
        idle(3);

        // Single 0xCC frame at N=4; also wraps the preset counter.
        snap();
        send(8'hCC, 1'b1, 4, 10, 1'b0);
        idle(12);
        chk("cc valid", vtot - v0, 1);
        chk("cc err", etot - e0, 0);
        chk("cc data", data_out, 8'hCC);
        chk("cc ch", ch_id, 2'd0);
        chk("cc cnt", frame_cnt, 16'd1);
        chk("wrap cnt", w_frame_cnt, 16'd0);
        chk("wrap data", {w_data_out, w_ch_id}, {8'hCC, 2'd0});

        for (int i = 0; i < 7; i++) begin
            sym = 24'(tbl[i].cfg);
            snap();
            send(tbl[i].w, tbl[i].stop, tbl[i].len, 10, 1'b0);
            idle(12);
            chk($sformatf("v%0d valid", i), vtot - v0, tbl[i].ev);
            chk($sformatf("v%0d err", i), etot - e0, tbl[i].ee);
            chk($sformatf("v%0d data", i), data_out, tbl[i].ed);
            chk($sformatf("v%0d ch", i), ch_id, tbl[i].ec);
            chk($sformatf("v%0d cnt", i), frame_cnt, tbl[i].en);
        end

        // Back-to-back 0xAA then 0x33 with no idle between stop and start.
        sym = 24'd4;
        snap();
        send(8'hAA, 1'b1, 4, 10, 1'b0);
        send(8'h33, 1'b1, 4, 10, 1'b0);
        idle(12);
        chk("b2b valid", vtot - v0, 2);
        chk("b2b first ch", ch_h1, 2'd1);
        chk("b2b first data", d_h1, 8'hAA);
        chk("b2b second ch", ch_h0, 2'd2);
        chk("b2b second data", d_h0, 8'h33);
        chk("b2b cnt", frame_cnt, 16'd8);

        // Two-cycle low glitch at N=8, then a real frame must still decode.
        sym = 24'd8;
        snap();
        d_in = 1'b0;
        idle(2);
        d_in = 1'b1;
        idle(40);
        chk("glitch valid", vtot - v0, 0);
        chk("glitch err", etot - e0, 0);
        snap();
        send(8'hCC, 1'b1, 8, 10, 1'b0);
        idle(12);
        chk("post-glitch valid", vtot - v0, 1);
        chk("post-glitch data", {data_out, ch_id}, {8'hCC, 2'd0});
        chk("post-glitch cnt", frame_cnt, 16'd9);

        // Period input changes 4 -> 9 mid-frame; frame keeps the latched 4.
        sym = 24'd4;
        snap();
        fork
            send(8'hAA, 1'b1, 4, 10, 1'b0);
            begin
                idle(12);
                sym = 24'd9;
            end
        join
        idle(12);
        chk("nchg valid", vtot - v0, 1);
        chk("nchg data", {data_out, ch_id}, {8'hAA, 2'd1});
        chk("nchg cnt", frame_cnt, 16'd10);

        // Bad stop with the line held low afterwards: no new start.
        sym = 24'd4;
        snap();
        send(8'h5A, 1'b0, 4, 10, 1'b1);
        idle(30);
        d_in = 1'b1;
        idle(12);
        chk("lowtail err", etot - e0, 1);
        chk("lowtail valid", vtot - v0, 0);
        chk("lowtail kept", {data_out, ch_id}, {8'hAA, 2'd1});
        chk("lowtail cnt", frame_cnt, 16'd10);

        // Reset pulsed while a frame at N=6 is in its data bits.
        sym = 24'd6;
        snap();
        send(8'hAA, 1'b1, 6, 6, 1'b0);
        rst = 1'b1;
        idle(3);
        chk("midrst data", data_out, 8'h00);
        chk("midrst ch", ch_id, 2'd3);
        chk("midrst cnt", frame_cnt, 16'd0);
        rst = 1'b0;
        idle(20);
        chk("midrst pulses", (vtot - v0) + (etot - e0), 0);
        snap();
        send(8'h33, 1'b1, 6, 10, 1'b0);
        idle(12);
        chk("after rst valid", vtot - v0, 1);
        chk("after rst data", {data_out, ch_id}, {8'h33, 2'd2});
        chk("after rst cnt", frame_cnt, 16'd1);

        chk("valid and err overlap", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/symbol_deserializer.md
SYMBOL_DESERIALIZER -- requirements
Module: symbol_deserializer

Interface
REQ-001 Parameter CYC_W, default 24: width of symbol_clk_cycles and of the internal symbol-period counter.
REQ-002 Parameter PAT0, default 8'hCC: word reported as ch_id 0.
REQ-003 Parameter PAT1, default 8'hAA: word reported as ch_id 1.
REQ-004 Parameter PAT2, default 8'h33: word reported as ch_id 2.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 Port d_in, input, 1 bit: serial stream from the upstream mode/symbol serializer (its d_out); idle high.
REQ-009 Port symbol_clk_cycles, input, CYC_W bits: clk cycles per symbol (N).
REQ-010 Port data_out, output, 8 bits: last correctly framed word.
REQ-011 Port data_valid, output, 1 bit: one-cycle pulse when data_out updates.
REQ-012 Port ch_id, output, 2 bits: 0/1/2 on match with PAT0/PAT1/PAT2; 3 on no match.
REQ-013 Port frame_err, output, 1 bit: one-cycle pulse on bad stop bit.
REQ-014 Port frame_cnt, output, 16 bits: count of good frames.

Function
REQ-015 d_in SHALL pass through a 2-flop synchronizer; all timing below refers to the synchronized bit s.
REQ-016 Frame format SHALL be: start bit 0, eight data bits MSB first, stop bit 1.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 IDLE SHALL go to START on a falling edge of s (previous 1, current 0) at cycle t0, latching N_eff = max(symbol_clk_cycles, 2).
REQ-019 symbol_clk_cycles changes after t0 SHALL be ignored until the next start detection.
REQ-020 START SHALL sample s at t0 + (N_eff>>1).
REQ-021 If the START sample is 1 (false start), the FSM SHALL return to IDLE with no pulse.
REQ-022 If the START sample is 0, the FSM SHALL enter DATA.
REQ-023 Data bit k (k = 0..7, MSB first) SHALL be sampled at t0 + (N_eff>>1) + (k+1)*N_eff.
REQ-024 After bit 7 the FSM SHALL enter STOP.
REQ-025 The stop bit SHALL be sampled at t0 + (N_eff>>1) + 9*N_eff.
REQ-026 Stop = 1: in the next cycle, data_out gets the word, ch_id is updated, data_valid pulses for 1 cycle, and frame_cnt increments.
REQ-027 Stop = 0: in the next cycle, frame_err pulses for 1 cycle; data_out, ch_id and frame_cnt are unchanged.
REQ-028 After either stop outcome the FSM SHALL return to IDLE.
REQ-029 frame_cnt SHALL wrap from 16'hFFFF to 0.
REQ-030 data_valid and frame_err SHALL never be high in the same cycle.
REQ-031 The FSM SHALL detect a new start edge in the cycle after returning to IDLE, allowing back-to-back frames.
REQ-032 The FSM SHALL detect no start while s stays low after a bad stop; a fresh 1-to-0 edge is required.

Reset
REQ-033 While rst = 1, the FSM SHALL be in IDLE, both synchronizer flops and the previous-sample flop SHALL be 1, data_out SHALL be 0, ch_id SHALL be 3, data_valid, frame_err and frame_cnt SHALL be 0, and counters SHALL be cleared.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-035 After reset release, operation SHALL resume from IDLE and wait for a new falling edge.

Verification
REQ-036 N=4, frame 0xCC with valid stop -> exactly one data_valid pulse, data_out=0xCC, ch_id=0, frame_cnt=1.
REQ-037 N=4, frames 0xAA then 0x33 back-to-back (no idle gap) -> two pulses, ch_id 1 then 2, frame_cnt=2.
REQ-038 N=8, d_in low for 2 cycles then high -> no data_valid, no frame_err, FSM back in IDLE.
REQ-039 N=4, frame 0x5A with stop=0 -> frame_err pulse once; data_out, ch_id and frame_cnt keep their prior values.
REQ-040 N=6, rst pulsed during bit 4 -> outputs at reset values; a subsequent 0x33 frame decodes with ch_id=2.
REQ-041 symbol_clk_cycles=0 -> frame sent at 2 cycles/bit decodes correctly; symbol_clk_cycles changed 4->9 mid-frame -> frame still decodes at 4; frame_cnt preset path 0xFFFF + 1 good frame -> 0.
